inst_queue: RTL

Instruction queue between the fetch stage and the decode stage. It buffers fetched {PC, instruction} pairs in a small FIFO so that instruction-memory latency and decode stalls are decoupled. Decode reads the queue head directly; its opcode and immediate-extension logic consume `id_inst` combinationally. On a control-flow redirect, `flush` discards every buffered entry.

---
 rtl/inst_queue.sv | 85 ++++++++
 1 files changed

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of {PC, instruction}
// pairs with flush-on-redirect and a NOP presented to decode when empty.
module inst_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [31:0]                id_pc,
    output logic [31:0]                id_inst,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [63:0]   head;

    // Handshake: a transfer happens on an edge where valid & ready are both
    // high; ready never looks at valid, and in_ready depends only on occupancy.
    assign in_ready = (count_q != CW'(DEPTH));
    assign id_valid = (count_q != '0);
    assign push     = in_valid & in_ready;
    assign pop      = id_valid & id_ready;
    assign count    = count_q;

    assign head    = mem_q[rptr_q];
    assign id_pc   = id_valid ? head[63:32] : 32'h0;
    assign id_inst = id_valid ? head[31:0]  : NOP_INST;

    // Storage has no reset; a push dropped by flush must not land either.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wptr_q] <= {in_pc, in_inst};
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule
